// File: rtl/fft_result_streamer_pkg.sv
// fft_consts: FFT size constants, complex sample type, streamer states
// and the bin bit-reversal helper shared by the result-unload path.
package fft_consts;

    localparam int N          = 1024;
    localparam int N_LOG2     = 10;
    localparam int DW         = 16;
    localparam int DW_COMPLEX = 2 * DW;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FINISH
    } stream_state_t;

    // Reverses the low w bits of k; upper result bits are zero.
    function automatic logic [31:0] bit_rev(
        input logic [31:0] k,
        input int          w = N_LOG2
    );
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        v = k;
        for (int b = 0; b < w; b++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// fft_result_streamer_if: valid/ready stream of complex bins with
// natural bin index and last-bin marker.
interface fft_result_streamer_if #(
    parameter int AW = fft_consts::N_LOG2
) ();
    import fft_consts::*;

    logic          m_valid;
    logic          m_ready;
    complex_t      m_data;
    logic [AW-1:0] m_index;
    logic          m_last;

    modport master (
        output m_valid, m_data, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_index, m_last,
        output m_ready
    );

endinterface

// File: rtl/fft_result_streamer_fifo.sv
// stream_skid_fifo: 2-entry FIFO for complex_t samples with an
// SW-bit sideband word travelling alongside each sample.
module stream_skid_fifo
    import fft_consts::*;
#(
    parameter int SW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  complex_t      push_data,
    input  logic [SW-1:0] push_side,
    input  logic          pop,
    output complex_t      head_data,
    output logic [SW-1:0] head_side,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    complex_t      data_q [2];
    logic [SW-1:0] side_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = count[1];
    assign empty     = (count == 2'd0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = data_q[rd_ptr];
    assign head_side = side_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            side_q[0] <= '0;
            side_q[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr] <= push_data;
                side_q[wr_ptr] <= push_side;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_result_streamer.sv
// fft_result_streamer: unloads a finished spectrum from the result RAM
// in natural bin order. FFT_STREAM_BITREV_EN unscrambles bit-reversed RAM.
module fft_result_streamer
    import fft_consts::*;
#(
    parameter int N_PTS = N,
    parameter int AW    = N_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  src_bank,
    output logic                  rd_en,
    output logic                  rd_bank,
    output logic [AW-1:0]         rd_addr,
    input  logic [DW_COMPLEX-1:0] rd_data,
    fft_result_streamer_if.master m,
    output logic                  busy,
    output logic                  done
);

    stream_state_t state;
    logic [AW:0]   iss_cnt;
    logic          inflight;
    logic [AW-1:0] inflight_idx;
    logic          bank_q;
    logic [AW-1:0] map_addr;
    logic [1:0]    fifo_count;
    logic [1:0]    credit;
    logic          fifo_empty;
    logic          unused_full;
    logic          pop;
    logic          last_hs;
    logic [AW:0]   head_side;

    assign pop     = m.m_valid && m.m_ready;
    assign last_hs = pop && m.m_last;

    // A slot freed by this cycle's pop is already available for a new read.
    assign credit = fifo_count - {1'b0, pop} + {1'b0, inflight};

    assign rd_en = (state == STREAM)
                && (iss_cnt < (AW+1)'(N_PTS))
                && (credit < 2'd2);

`ifdef FFT_STREAM_BITREV_EN
    assign map_addr = AW'(bit_rev(32'(iss_cnt[AW-1:0]), AW));
`else
    assign map_addr = iss_cnt[AW-1:0];
`endif

    assign rd_addr = rd_en ? map_addr : '0;
    assign rd_bank = bank_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            iss_cnt      <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            bank_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            inflight <= rd_en;
            done     <= 1'b0;
            if (rd_en) begin
                inflight_idx <= iss_cnt[AW-1:0];
                iss_cnt      <= iss_cnt + (AW+1)'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        iss_cnt <= '0;
                        bank_q  <= src_bank;
                        busy    <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last_hs) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    stream_skid_fifo #(
        .SW(AW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (complex_t'(rd_data)),
        .push_side ({inflight_idx, inflight_idx == AW'(N_PTS - 1)}),
        .pop       (pop),
        .head_data (m.m_data),
        .head_side (head_side),
        .full      (unused_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_index = head_side[AW:1];
    assign m.m_last  = head_side[0];

endmodule
